abs_share_arb: RTL and testbench

- Shares one pipelined single-operand math unit (abs or any same-shaped component: clk, a in, z out, fixed latency) between NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the winning operand into the unit and carries the requester ID down a tag pipeline matched to the unit latency.
- Returns each result on a shared response bus tagged with the originating requester.

---
 rtl/abs_share_pkg.sv | 20 ++
 rtl/abs_share_arb_rr_arbiter.sv | 33 +++
 rtl/abs_share_arb.sv | 89 ++++++++
 tb/tb_abs_share_arb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/abs_share_pkg.sv
// abs_share_pkg: shared constants, clog2 helper and tag record for abs_share_arb.
package abs_share_pkg;

    localparam int ABS_SHARE_NREQ    = 4;
    localparam int ABS_SHARE_LATENCY = 1;
    localparam int ABS_SHARE_ID_MAX  = 3;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef struct packed {
        logic                        valid;
        logic [ABS_SHARE_ID_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/abs_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import abs_share_pkg::*;
#(
    parameter int NREQ     = ABS_SHARE_NREQ,
    parameter int ID_WIDTH = clog2(NREQ)
) (
    input  logic [NREQ-1:0]     req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    input  logic                en_i,
    output logic [NREQ-1:0]     grant_o,
    output logic [ID_WIDTH-1:0] g_o
);

    localparam logic [ID_WIDTH:0] N = (ID_WIDTH+1)'(NREQ);

    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        g_o = '0;
        sum = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (ID_WIDTH+1)'(k);
            idx = ID_WIDTH'((sum >= N) ? sum - N : sum);
            if (req_i[idx]) g_o = idx;
        end
        grant_o = (en_i && |req_i) ? NREQ'(1) << g_o : '0;
    end

endmodule

// File: rtl/abs_share_arb.sv
// abs_share_arb: round-robin sharing of one pipelined single-operand unit among NREQ requesters.
// Optional grant counter on perf_grants when ABS_SHARE_PERF_EN is defined.
module abs_share_arb
    import abs_share_pkg::*;
#(
    parameter int NREQ     = ABS_SHARE_NREQ,
    parameter int WIDTH    = 32,
    parameter int ID_WIDTH = 2,
    parameter int LATENCY  = ABS_SHARE_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      unit_a,
    input  logic [WIDTH-1:0]      unit_z,
    output logic                  rsp_valid,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic [31:0]           perf_grants
);

    if (ID_WIDTH != clog2(NREQ) || NREQ < 2 || NREQ > 8 || LATENCY < 1) begin : g_bad_params
        $error("abs_share_arb: illegal NREQ/ID_WIDTH/LATENCY combination");
    end

    logic [NREQ-1:0]     grant;
    logic [ID_WIDTH-1:0] g;
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;
    logic [WIDTH-1:0]    unit_a_q;
    logic                hs;
    // Stage 0 travels alongside unit_a; stages 1..LATENCY mirror the unit itself.
    tag_t                tag_q [LATENCY+1];

    rr_arbiter #(.NREQ(NREQ), .ID_WIDTH(ID_WIDTH)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (en & rst_n),
        .grant_o (grant),
        .g_o     (g)
    );

    assign req_ready = grant;
    assign hs        = |(req_valid & grant);
    assign ptr_d     = (g == ID_WIDTH'(NREQ - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            unit_a_q <= '0;
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
        end else begin
            if (hs) begin
                ptr_q    <= ptr_d;
                unit_a_q <= WIDTH'(req_data >> (int'(g) * WIDTH));
            end
            tag_q[0] <= '{valid: hs, id: ABS_SHARE_ID_MAX'(g)};
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LATENCY; i++) busy = busy | tag_q[i].valid;
    end

    assign unit_a    = unit_a_q;
    assign rsp_valid = tag_q[LATENCY].valid;
    assign rsp_id    = ID_WIDTH'(tag_q[LATENCY].id);
    assign rsp_data  = unit_z;

`ifdef ABS_SHARE_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else if (hs) perf_q <= perf_q + 32'd1;
    end

    assign perf_grants = perf_q;
`else
    assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_abs_share_arb.sv
// tb_abs_share_arb: scoreboard bench for abs_share_arb against a round-robin/abs reference model.
module tb_abs_share_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int L  = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    unit_a;
    logic [W-1:0]    unit_z;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
    logic            busy;
    logic [31:0]     perf_grants;

    always #5 clk = ~clk;

    abs_share_arb #(.NREQ(N), .WIDTH(W), .ID_WIDTH(IW), .LATENCY(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .unit_a      (unit_a),
        .unit_z      (unit_z),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .perf_grants (perf_grants)
    );

    function automatic logic [W-1:0] absf(input logic [W-1:0] d);
        return d[W-1] ? -d : d;
    endfunction

    // One-cycle abs unit (LATENCY = 1).
    always_ff @(posedge clk) unit_z <= absf(unit_a);

    typedef struct {
        int         id;
        logic [W-1:0] data;
        int         due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ptr = 0;
    logic [31:0] perf_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: round-robin grant and expected response per handshake.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        int g;
        eg = '0;
        g  = -1;
        if (rst_n && en)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
`ifdef ABS_SHARE_PERF_EN
        if (rst_n) chk("perf_grants", 64'(perf_grants), 64'(perf_exp));
`else
        chk("perf_grants", 64'(perf_grants), 64'd0);
`endif
        if (!rst_n) begin
            ptr = 0;
            q.delete();
            perf_exp = '0;
        end else if (g >= 0) begin
            ptr = (g + 1) % N;
            q.push_back('{g, absf(req_data[g*W +: W]), cyc + 1 + L});
            perf_exp = perf_exp + 32'd1;
        end
    end

    // Monitor: response timing, id, data and busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_unit_a", 64'(unit_a), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_perf", 64'(perf_grants), 64'd0);
        end else begin
            bit eb;
            eb = 1'b0;
            foreach (q[i]) if (q[i].due - 1 <= cyc) eb = 1'b1;
            chk("busy", 64'(busy), 64'(eb));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'd1);
                if (rsp_valid) begin
                    chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
                    chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
                end
                void'(q.pop_front());
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every requester valid; first grant after release must be 0.
        en = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = -(W'(i + 1));
        step(3);
        rst_n = 1'b1;
        step(10);
        // Single request from requester 2.
        req_valid = '0;
        step(3);
        req_valid = 4'b0100;
        req_data[2*W +: W] = 32'hFFFF_FFF6;
        step(1);
        req_valid = '0;
        step(3);
        // en dropped with two ops in flight and requests pending.
        req_valid = '1;
        step(2);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(4);
        req_valid = '0;
        step(3);
        // Reset pulse the cycle after two issues.
        req_valid = '1;
        step(2);
        rst_n = 1'b0;
        req_valid = '0;
        step(1);
        rst_n = 1'b1;
        step(3);
`ifdef ABS_SHARE_PERF_EN
        force dut.perf_q = 32'hFFFF_FFFF;
        perf_exp = 32'hFFFF_FFFF;
        step(1);
        release dut.perf_q;
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        step(2);
        chk("perf_wrap", 64'(perf_grants), 64'd0);
`endif
        // Randomised traffic with occasional en drops and resets.
        repeat (3000) begin
            en = ($urandom_range(0, 9) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                req_data[i*W +: W] = ($urandom_range(0, 3) == 0) ? -W'($urandom_range(0, 20)) : W'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step(1);
            rst_n = 1'b1;
        end
        req_valid = '0;
        step(L + 4);
        chk("drain_queue", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
